// File: rtl/mlp_din_loader.sv
// mlp_din_loader: turns toggle-marked HPS Din writes into a buffered
// first-word-fall-through valid/ready sample stream for the MLP input layer,
// and reports ACK/OVF/EMPTY/FULL/count/word-counter on a 32-bit status word.
// Optional feature macro: DIN_LOADER_WORDCNT_EN builds the accepted-word
// counter in status[15:0]; when undefined, status[15:0] is constant 0.
module mlp_din_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       din,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic [31:0]       status
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 1 + IDX_W + DATA_W;

  localparam int unsigned TOG_B  = 31;
  localparam int unsigned LAST_B = 30;
  localparam int unsigned CTRL_B = 29;
  localparam int unsigned IDX_LO = 16;

  logic [31:0]      din_q;
  logic             tog_prev_q;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, full_q;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      wcnt_field;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head;

  logic evt, data_evt, ctrl_evt, pop, push, drop;

  // Reserved din bits are deliberately ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^din_q[28:24];

  // Event decode and FIFO handshake qualification.
  assign evt      = din_q[TOG_B] != tog_prev_q;
  assign data_evt = evt && !din_q[CTRL_B];
  assign ctrl_evt = evt && din_q[CTRL_B];
  assign pop      = m_valid && m_ready;
  assign push     = data_evt && (!full_q || pop);
  assign drop     = data_evt && full_q && !pop;

  // Input capture and toggle history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q      <= '0;
      tog_prev_q <= 1'b0;
    end else begin
      din_q <= din;
      if (evt) tog_prev_q <= din_q[TOG_B];
    end
  end

  // Next-state for pointers, occupancy and sticky/ack flags; flush dominates.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ack_d   = ack_q;
    ovf_d   = ovf_q;
    if (ctrl_evt) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      ack_d   = din_q[TOG_B];
    end else begin
      if (push) begin
        wr_d  = wr_q + PTR_W'(1);
        ack_d = din_q[TOG_B];
      end
      if (drop) ovf_d = 1'b1;
      if (pop) rd_d = rd_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // FIFO control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_W'(DEPTH));
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written, pointers gate use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {din_q[LAST_B], din_q[IDX_LO +: IDX_W], din_q[DATA_W-1:0]};
  end

`ifdef DIN_LOADER_WORDCNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  // Accepted-word counter, cleared by control events.
  always_comb begin
    wcnt_d = wcnt_q;
    if (ctrl_evt) begin
      wcnt_d = '0;
    end else if (push) begin
      wcnt_d = wcnt_q + 16'(1);
    end
  end

  // Word counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end

  assign wcnt_field = wcnt_q;
`else
  assign wcnt_field = '0;
`endif

  // FWFT head: read straight from the array, zeroed while empty.
  assign head    = mem[rd_q];
  assign m_valid = !empty_q;
  assign m_last  = m_valid & head[ENT_W-1];
  assign m_index = m_valid ? head[DATA_W +: IDX_W] : '0;
  assign m_data  = m_valid ? head[DATA_W-1:0] : '0;

  assign status = {ack_q, ovf_q, empty_q, full_q, 4'b0000, 8'(count_q), wcnt_field};

endmodule
